aclk_alarm_sequencer: RTL
=========================

Name: aclk_alarm_sequencer

Overview:
- Sequences the alarm-sounding side of the alarm clock.
- Compares the running clock time against the stored alarm time and drives the buzzer request.
- Handles stop, snooze (bounded repeat count) and ring auto-timeout.
- Sits beside the key/time FSM controller and consumes the same one_second strobe, current-time bus and alarm-time register outputs.

Parameters:
- SNOOZE_SEC, 300, one_second pulses spent in SNOOZE before ringing again.
- RING_TIMEOUT_SEC, 60, one_second pulses of continuous ringing before auto-silence.
- MAX_SNOOZE, 3, maximum snoozes per alarm event; width of snooze_count is 4 bits, so MAX_SNOOZE must be 15 or less.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- one_second  input  1  single-cycle strobe, once per second.
- current_time  input  16  BCD HH:MM of the running clock, as {h_ms, h_ls, m_ms, m_ls}.
- alarm_time  input  16  BCD HH:MM of the stored alarm, same format.
- alarm_on  input  1  alarm enable switch (level).
- stop_button  input  1  silence request (level).
- snooze_button  input  1  snooze request; rising edge detected internally.
- sound_alarm  output  1  buzzer enable.
- snooze_active  output  1  high while in SNOOZE.
- snooze_count  output  4  snoozes used in the current alarm event.
- time_match  output  1  combinational: current_time == alarm_time.

Behaviour:
- Reset is asynchronous, active-high. It forces state DISARMED and clears timer, snooze_count and snooze_d. Outputs at reset: sound_alarm=0, snooze_active=0, snooze_count=0.
- snooze_press = snooze_button & ~snooze_d, where snooze_d is snooze_button registered every clock.
- States: DISARMED, ARMED, RINGING, SNOOZE, LOCKOUT. The state register is clocked by clock.
- Global override: alarm_on=0 in any state sends next state to DISARMED. It takes priority over all other transitions.
- DISARMED:
  - alarm_on=1 and time_match=1 -> LOCKOUT. Enabling during the alarm minute must not ring.
  - alarm_on=1 and time_match=0 -> ARMED.
- ARMED: time_match=1 -> RINGING; clear snooze_count and timer.
- RINGING, priority stop > snooze > timeout:
  - stop_button=1 -> LOCKOUT.
  - snooze_press and snooze_count<MAX_SNOOZE -> SNOOZE; snooze_count+1; timer cleared.
  - snooze_press and snooze_count==MAX_SNOOZE -> ignored, stay RINGING.
  - one_second and timer==RING_TIMEOUT_SEC-1 -> LOCKOUT.
  - otherwise, timer increments on each one_second.
- SNOOZE:
  - stop_button=1 -> LOCKOUT.
  - one_second and timer==SNOOZE_SEC-1 -> RINGING; timer cleared.
  - otherwise, timer increments on each one_second.
  - snooze_press is ignored in this state.
- LOCKOUT: time_match=0 -> ARMED. This prevents re-ringing within the same matched minute.
- Timer:
  - Width is clog2(max(SNOOZE_SEC, RING_TIMEOUT_SEC)+1).
  - Cleared on every state change.
  - Never wraps; the terminal count always causes a transition.
- Outputs are a Moore decode of the present state:
  - sound_alarm = (state==RINGING).
  - snooze_active = (state==SNOOZE).
  - snooze_count is a register.
- Latency: an input condition sampled at clock edge N changes the state at edge N; the outputs reflect it in the cycle after edge N. This is one cycle of latency; there is no combinational path from inputs to sound_alarm.
- Mid-operation reset: the asynchronous reset immediately drops sound_alarm and snooze_active.
- snooze_count holds its value through LOCKOUT and ARMED. It is cleared only on the ARMED->RINGING transition and on reset.

Test Plan:
1. Basic ring and stop (SNOOZE_SEC=5, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2; alarm_on=1, alarm_time=16'h0730). Step current_time from 16'h0729 to 16'h0730 -> sound_alarm=1 one cycle later. Pulse stop_button -> sound_alarm=0; no re-ring while current_time stays 16'h0730; state returns to ARMED at 16'h0731.
2. Snooze cycle (same parameters). While ringing, pulse snooze_button -> snooze_active=1, snooze_count=1. After 5 one_second pulses -> sound_alarm=1 again. Snooze again -> snooze_count=2. At the third ring, snooze_press is ignored and sound_alarm stays 1.
3. Auto-timeout. Ring with no buttons pressed -> sound_alarm falls exactly on the 4th one_second pulse after RINGING entry; state is LOCKOUT.
4. Held snooze_button. Hold snooze_button high across the SNOOZE->RINGING return -> no second snooze (edge detection); snooze_count unchanged.
5. Disable and enable inside the match.
   - Set alarm_on=0 while in RINGING or SNOOZE -> sound_alarm=0 and snooze_active=0 next cycle.
   - Set alarm_on=1 while current_time==alarm_time -> no ring until the next match.
6. Priority and reset.
   - Assert stop_button and snooze rising edge in the same cycle -> LOCKOUT, snooze_count unchanged.
   - Assert reset mid-RINGING -> sound_alarm=0 immediately and snooze_count=0.

Source files
------------

// File: rtl/aclk_alarm_sequencer.sv
// Alarm-sounding sequencer: compares running time with the alarm time and drives the
// buzzer request, with stop, bounded snooze and ring auto-timeout.
module aclk_alarm_sequencer #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        one_second,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  input  logic        alarm_on,
  input  logic        stop_button,
  input  logic        snooze_button,
  output logic        sound_alarm,
  output logic        snooze_active,
  output logic [3:0]  snooze_count,
  output logic        time_match
);

  localparam int TMAX = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SEC - 1);
  localparam logic [TW-1:0] RING_LAST   = TW'(RING_TIMEOUT_SEC - 1);
  localparam logic [3:0]    MAX_CNT     = 4'(MAX_SNOOZE);

  typedef enum logic [2:0] {
    DISARMED,
    ARMED,
    RINGING,
    SNOOZE,
    LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      count_q, count_d;
  logic            snooze_btn_q;
  logic            snooze_press;

  assign time_match   = (current_time == alarm_time);
  assign snooze_press = snooze_button & ~snooze_btn_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= DISARMED;
      timer_q      <= '0;
      count_q      <= '0;
      snooze_btn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      snooze_btn_q <= snooze_button;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    case (state_q)
      // Enabling inside the alarm minute goes to LOCKOUT so it cannot ring until the next match.
      DISARMED: state_d = time_match ? LOCKOUT : ARMED;
      ARMED: begin
        if (time_match) begin
          state_d = RINGING;
          count_d = '0;
        end
      end
      RINGING: begin
        if (stop_button) begin
          state_d = LOCKOUT;
        end else if (snooze_press && (count_q < MAX_CNT)) begin
          state_d = SNOOZE;
          count_d = count_q + 4'd1;
        end else if (one_second) begin
          if (timer_q == RING_LAST) state_d = LOCKOUT;
          else                      timer_d = timer_q + 1'b1;
        end
      end
      SNOOZE: begin
        if (stop_button) begin
          state_d = LOCKOUT;
        end else if (one_second) begin
          if (timer_q == SNOOZE_LAST) state_d = RINGING;
          else                        timer_d = timer_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (!time_match) state_d = ARMED;
      end
      default: state_d = DISARMED;
    endcase
    // Disabling overrides everything, including any count update decided above.
    if (!alarm_on) begin
      state_d = DISARMED;
      count_d = count_q;
    end
    if (state_d != state_q) timer_d = '0;
  end

  assign sound_alarm   = (state_q == RINGING);
  assign snooze_active = (state_q == SNOOZE);
  assign snooze_count  = count_q;

endmodule
